// File: rtl/cell_painter.sv
// cell_painter: turns tracker cell changes into 8080-bus rectangle fills on the display,
// pausing the tracker scan while each fill is in flight.
module cell_painter #(
    parameter int CELL_W = 20,
    parameter int CELL_H = 20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        run,
    input  logic        diff,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic [2:0]  obj_code,
    output logic        tracker_en,
    output logic        busy,
    output logic        lcd_cs_n,
    output logic        lcd_dcx,
    output logic        lcd_wr_n,
    output logic [7:0]  lcd_data,
    output logic [15:0] cells_drawn
);
    localparam int NPIX = CELL_W * CELL_H;
    localparam int PW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, HDR, PIX} state_t;

    state_t          state_q, state_d;
    logic            phase_q, phase_d;
    logic            lo_q, lo_d;
    logic [3:0]      byte_q, byte_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [3:0]      x_q, x_d, y_q, y_d;
    logic [15:0]     col_q, col_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     x0, x1, y0, y1;
    logic [7:0]      hdr_byte;

    function automatic logic [15:0] colour(input logic [2:0] c);
        case (c)
            3'b001:  return 16'h07E0;
            3'b010:  return 16'h03E0;
            3'b011:  return 16'hF800;
            3'b100:  return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    assign x0 = 16'(x_q) * 16'(CELL_W);
    assign x1 = x0 + 16'(CELL_W - 1);
    assign y0 = 16'(y_q) * 16'(CELL_H);
    assign y1 = y0 + 16'(CELL_H - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            lo_q    <= 1'b0;
            byte_q  <= '0;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            pix_q   <= pix_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    // phase_q: 0 = strobe low (L), 1 = strobe high (H); counters advance after H
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        lo_d    = lo_q;
        byte_d  = byte_q;
        pix_d   = pix_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (run && diff) begin
                state_d = HDR;
                x_d     = x;
                y_d     = y;
                col_d   = colour(obj_code);
                byte_d  = '0;
                phase_d = 1'b0;
            end
            HDR: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    byte_d = byte_q + 4'd1;
                    if (byte_q == 4'd10) begin
                        state_d = PIX;
                        byte_d  = '0;
                        pix_d   = '0;
                        lo_d    = 1'b0;
                    end
                end
            end
            PIX: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    lo_d = !lo_q;
                    if (lo_q) begin
                        pix_d = pix_q + PW'(1);
                        if (pix_q == PW'(NPIX - 1)) begin
                            state_d = IDLE;
                            pix_d   = '0;
                            cnt_d   = cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (byte_q)
            4'd0:    hdr_byte = 8'h2A;
            4'd1:    hdr_byte = x0[15:8];
            4'd2:    hdr_byte = x0[7:0];
            4'd3:    hdr_byte = x1[15:8];
            4'd4:    hdr_byte = x1[7:0];
            4'd5:    hdr_byte = 8'h2B;
            4'd6:    hdr_byte = y0[15:8];
            4'd7:    hdr_byte = y0[7:0];
            4'd8:    hdr_byte = y1[15:8];
            4'd9:    hdr_byte = y1[7:0];
            default: hdr_byte = 8'h2C;
        endcase
    end

    assign busy        = state_q != IDLE;
    assign tracker_en  = run && !busy;
    assign lcd_cs_n    = !busy;
    assign lcd_wr_n    = !(busy && !phase_q);
    assign lcd_dcx     = (state_q == HDR) ? !(byte_q == 4'd0 || byte_q == 4'd5 || byte_q == 4'd10) : 1'b1;
    assign lcd_data    = (state_q == HDR) ? hdr_byte :
                         (state_q == PIX) ? (lo_q ? col_q[7:0] : col_q[15:8]) : 8'h00;
    assign cells_drawn = cnt_q;
endmodule
